// File: rtl/pc_sequencer.sv
// Program-counter sequencer: applies jump/branch redirects with a one-cycle flush
// bubble and maintains a small return-address stack for jal / jr ra.
module pc_sequencer #(
  parameter int unsigned PC_W      = 4,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  input  logic            link,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [RA_W-1:0] ra_top,
  output logic            fetch_valid,
  output logic            flush,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [RA_W-1:0]   ras_q [RAS_DEPTH];
  logic [RA_W-1:0]   ras_d [RAS_DEPTH];

  logic              ras_empty;
  logic              ras_full;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  sp_idx;
  logic [RA_W-1:0]   push_val;
  logic [SP_W-1:0]   sp_dec;

  // Stack occupancy and the return address a jal at the current pc would push.
  assign ras_empty = (sp_q == '0);
  assign ras_full  = (sp_q == SP_W'(RAS_DEPTH));
  assign sp_dec    = sp_q - SP_W'(1);
  assign top_idx   = sp_dec[IDX_W-1:0];
  assign sp_idx    = sp_q[IDX_W-1:0];
  assign push_val  = RA_W'(pc_q) + RA_W'(1);
  assign ra_top    = ras_empty ? '0 : ras_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      sp_q          <= '0;
      ras_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      sp_q          <= sp_d;
      ras_q         <= ras_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    sp_d    = sp_q;
    ras_d   = ras_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (!run) begin
          state_d = IDLE;
        end else if (stall) begin
          state_d = FETCH;
        end else if (redirect) begin
          state_d = FLUSH;
          pc_d    = ret ? ra_top[PC_W-1:0] : target;
          case ({link, ret})
            2'b10: begin
              if (ras_full) begin
                ovf_d = 1'b1;
              end else begin
                ras_d[sp_idx] = push_val;
                sp_d          = sp_q + SP_W'(1);
              end
            end
            2'b01: begin
              if (ras_empty) unf_d = 1'b1;
              else           sp_d  = sp_dec;
            end
            2'b11: begin
              // Pop-then-push: on an empty stack the pop underflows and the push still lands.
              if (ras_empty) begin
                unf_d    = 1'b1;
                ras_d[0] = push_val;
                sp_d     = SP_W'(1);
              end else begin
                ras_d[top_idx] = push_val;
              end
            end
            default: ;
          endcase
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      FLUSH: begin
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    fetch_valid_d = (state_d == FETCH);
    flush_d       = (state_d == FLUSH);
  end

  assign pc            = pc_q;
  assign fetch_valid   = fetch_valid_q;
  assign flush         = flush_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: the driver queues hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor checks them.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       stall;
  logic       redirect;
  logic [3:0] target;
  logic       link;
  logic       ret;
  logic [3:0] pc;
  logic [4:0] ra_top;
  logic       fetch_valid;
  logic       flush;
  logic       ras_overflow;
  logic       ras_underflow;

  typedef struct {
    string      name;
    int         when;
    logic [3:0] pc;
    logic [4:0] ra;
    logic       fv;
    logic       fl;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc_cnt = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  pc_sequencer #(.PC_W(4), .RA_W(5), .RAS_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .stall        (stall),
    .redirect     (redirect),
    .target       (target),
    .link         (link),
    .ret          (ret),
    .pc           (pc),
    .ra_top       (ra_top),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due at this cycle against the DUT outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].when <= cyc_cnt) begin
      cur = exp_q.pop_front();
      n_vec++;
      if (cur.when < cyc_cnt) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", cur.name, cur.when, cyc_cnt);
      end else if ({pc, ra_top, fetch_valid, flush, ras_overflow, ras_underflow} !==
                   {cur.pc, cur.ra, cur.fv, cur.fl, cur.ov, cur.un}) begin
        n_fail++;
        $display("FAIL %s @%0d: got pc=%0d ra_top=%0d fv=%b flush=%b ovf=%b unf=%b, want pc=%0d ra_top=%0d fv=%b flush=%b ovf=%b unf=%b",
                 cur.name, cyc_cnt, pc, ra_top, fetch_valid, flush, ras_overflow, ras_underflow,
                 cur.pc, cur.ra, cur.fv, cur.fl, cur.ov, cur.un);
      end
    end
  end

  task automatic step(input string nm, input logic rs, input logic rn, input logic st,
                      input logic rd, input logic [3:0] tg, input logic lk, input logic rt,
                      input logic [3:0] epc, input logic [4:0] era, input logic efv,
                      input logic efl, input logic eov, input logic eun);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rs;
    run      = rn;
    stall    = st;
    redirect = rd;
    target   = tg;
    link     = lk;
    ret      = rt;
    e.name = nm;
    e.when = cyc_cnt + 1;
    e.pc = epc; e.ra = era; e.fv = efv; e.fl = efl; e.ov = eov; e.un = eun;
    exp_q.push_back(e);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0; redirect = 1'b0;
    target = 4'd0; link = 1'b0; ret = 1'b0;

    //    name         rs rn st rd tg  lk rt | pc  ra fv fl ov un
    step("reset",       1, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0);
    step("start",       0, 1, 0, 0, 0,  0, 0,  0,  0, 1, 0, 0, 0);
    for (int i = 1; i < 18; i++)
      step("count",     0, 1, 0, 0, 0,  0, 0,  4'(i % 16), 0, 1, 0, 0, 0);
    step("to2",         0, 1, 0, 0, 0,  0, 0,  2,  0, 1, 0, 0, 0);
    step("to3",         0, 1, 0, 0, 0,  0, 0,  3,  0, 1, 0, 0, 0);
    step("redir9",      0, 1, 0, 1, 9,  0, 0,  9,  0, 0, 1, 0, 0);
    step("tgt9_valid",  0, 1, 0, 0, 0,  0, 0,  9,  0, 1, 0, 0, 0);
    step("tgt10",       0, 1, 0, 0, 0,  0, 0, 10,  0, 1, 0, 0, 0);
    step("redir2",      0, 1, 0, 1, 2,  0, 0,  2,  0, 0, 1, 0, 0);
    step("at2",         0, 1, 0, 0, 0,  0, 0,  2,  0, 1, 0, 0, 0);
    step("jal12",       0, 1, 0, 1, 12, 1, 0, 12,  3, 0, 1, 0, 0);
    step("at12",        0, 1, 0, 0, 0,  0, 0, 12,  3, 1, 0, 0, 0);
    step("at13",        0, 1, 0, 0, 0,  0, 0, 13,  3, 1, 0, 0, 0);
    step("jr_ra",       0, 1, 0, 1, 7,  0, 1,  3,  0, 0, 1, 0, 0);
    step("at3",         0, 1, 0, 0, 0,  0, 0,  3,  0, 1, 0, 0, 0);
    step("stall_hold",  0, 1, 1, 1, 5,  1, 0,  3,  0, 1, 0, 0, 0);
    step("ret_empty",   0, 1, 0, 1, 9,  0, 1,  0,  0, 0, 1, 0, 1);
    step("at0",         0, 1, 0, 0, 0,  0, 0,  0,  0, 1, 0, 0, 1);
    step("push1",       0, 1, 0, 1, 4,  1, 0,  4,  1, 0, 1, 0, 1);
    step("at4",         0, 1, 0, 0, 0,  0, 0,  4,  1, 1, 0, 0, 1);
    step("push5",       0, 1, 0, 1, 8,  1, 0,  8,  5, 0, 1, 0, 1);
    step("at8",         0, 1, 0, 0, 0,  0, 0,  8,  5, 1, 0, 0, 1);
    step("push9",       0, 1, 0, 1, 15, 1, 0, 15,  9, 0, 1, 0, 1);
    step("at15",        0, 1, 0, 0, 0,  0, 0, 15,  9, 1, 0, 0, 1);
    step("push16",      0, 1, 0, 1, 1,  1, 0,  1, 16, 0, 1, 0, 1);
    step("at1",         0, 1, 0, 0, 0,  0, 0,  1, 16, 1, 0, 0, 1);
    step("push_full",   0, 1, 0, 1, 6,  1, 0,  6, 16, 0, 1, 1, 1);
    step("at6",         0, 1, 0, 0, 0,  0, 0,  6, 16, 1, 0, 1, 1);
    step("link_ret",    0, 1, 0, 1, 3,  1, 1,  0,  7, 0, 1, 1, 1);
    step("flush_ign",   0, 1, 0, 1, 3,  0, 1,  0,  7, 1, 0, 1, 1);
    step("pop7",        0, 1, 0, 1, 2,  0, 1,  7,  9, 0, 1, 1, 1);
    step("at7",         0, 1, 0, 0, 0,  0, 0,  7,  9, 1, 0, 1, 1);
    step("idle",        0, 0, 0, 0, 0,  0, 0,  7,  9, 0, 0, 1, 1);
    step("idle_redir",  0, 0, 0, 1, 2,  1, 0,  7,  9, 0, 0, 1, 1);
    step("resume",      0, 1, 0, 0, 0,  0, 0,  7,  9, 1, 0, 1, 1);
    step("redir11",     0, 1, 0, 1, 11, 0, 0, 11,  9, 0, 1, 1, 1);
    step("flush_stop",  0, 0, 0, 0, 0,  0, 0, 11,  9, 0, 0, 1, 1);
    step("resume11",    0, 1, 0, 0, 0,  0, 0, 11,  9, 1, 0, 1, 1);
    step("redir5",      0, 1, 0, 1, 5,  0, 0,  5,  9, 0, 1, 1, 1);
    step("rst_flush",   1, 1, 0, 0, 0,  0, 0,  0,  0, 0, 0, 0, 0);
    step("post_rst",    0, 1, 0, 0, 0,  0, 0,  0,  0, 1, 0, 0, 0);
    step("post_rst1",   0, 1, 0, 0, 0,  0, 0,  1,  0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
